acc_cpu_core: RTL
=================

# acc_cpu_core

Parametrised multi-cycle accumulator processor core. It is the successor to the team's fixed 8-bit accumulator processor. Data width, register-file depth and PC width are generic. Instruction fetch uses a request/valid handshake so slow program memory can stall the core. The core adds carry-in arithmetic, shifts, conditional branches on registered flags, and a sticky HALT state. It sits between a program memory (which supplies INST) and the system top, which observes ACC, PC and the status outputs.

## Interface
- DATA_W, 8: width of ACC, register-file entries and ALU datapath (≥4).
- REG_AW, 4: register-file address width; 2**REG_AW registers. Also the operand-field width.
- PC_W, 8: program-counter width.
- INST_W, 4+REG_AW: derived, not overridable. Format is opcode[INST_W-1:INST_W-4] followed by field[REG_AW-1:0].

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- CLB  in  1  reset, asynchronous, active-high.
- INST  in  INST_W  instruction word addressed by PC.
- INST_VALID  in  1  INST is valid this cycle.
- INST_REQ  out  1  core is requesting the instruction at PC.
- PC  out  PC_W  program counter.
- ACC  out  DATA_W  accumulator.
- FLAG_Z  out  1  registered zero flag.
- FLAG_C  out  1  registered carry/borrow flag.
- HALTED  out  1  core is in the HALT state.

## Operation
- State machine states: FETCH, EXEC, HALT.
  - FETCH → EXEC when INST_VALID=1; the IR captures INST.
  - EXEC → FETCH after executing the IR; EXEC → HALT if the opcode is HLT.
  - HALT is sticky; only CLB leaves it.
- Reset (CLB=1, any state, mid-instruction included) sets:
  - state=FETCH; PC, ACC, IR and every register to 0; FLAG_Z=1, FLAG_C=0.
- Opcodes (f = field, R = R[f], zx = zero-extend):
  - 0 NOP.
  - 1 LDI: ACC←zx(f).
  - 2 LDR: ACC←R.
  - 3 STR: R←ACC.
  - 4 ADD: ACC←ACC+R.
  - 5 ADC: ACC←ACC+R+C.
  - 6 SUB: ACC←ACC−R; C=1 on borrow (ACC<R unsigned).
  - 7 AND, 8 OR, 9 XOR: ACC←ACC op R.
  - A SHL: ACC←ACC<<1; C←old ACC[MSB].
  - B SHR (logical): ACC←ACC>>1; C←old ACC[0].
  - C JMP: PC←R[PC_W-1:0], zero-extended if PC_W>DATA_W.
  - D JZ: jump as JMP if FLAG_Z=1.
  - E JC: jump as JMP if FLAG_C=1.
  - F HLT.
- Flags:
  - Z is updated by every opcode that writes ACC, and equals (new ACC==0).
  - C is updated only by ADD, ADC, SUB, SHL and SHR. AND/OR/XOR/LDI/LDR leave C unchanged.
  - Arithmetic is computed DATA_W+1 wide; C is the extra bit.
- PC update:
  - PC←PC+1 modulo 2**PC_W in EXEC for all non-taken-jump, non-HLT opcodes; 2**PC_W−1 wraps to 0.
  - A taken jump loads the target with no increment.
  - HLT leaves PC at the HLT address.
- Register 0 is a normal writable register.

## Timing
- INST_REQ=1 exactly when state=FETCH. It is 0 in EXEC, HALT and during reset.
- PC is stable for the whole FETCH wait; INST may change freely while INST_VALID=0.
- Zero-wait memory: 2 cycles per instruction (FETCH, EXEC). Each wait cycle with INST_VALID=0 in FETCH adds 1.
- ACC, flags, register write and PC all update on the EXEC→next edge and are visible in the following FETCH cycle.
- INST_VALID outside FETCH is ignored.
- JZ/JC test the flag values registered before this instruction.
- HALTED=1 from the cycle after the HLT EXEC edge.
- Reset values of outputs: PC=0, ACC=0, FLAG_Z=1, FLAG_C=0, HALTED=0, INST_REQ=0 while CLB=1, and INST_REQ=1 in the first cycle after release.

## Structure
- Package acc_cpu_pkg holds:
  - opcode localparams (OP_NOP … OP_HLT);
  - state enum (ST_FETCH, ST_EXEC, ST_HALT);
  - the ALU-op encoding.
- Sub-module acc_cpu_alu: combinational, parametrised by DATA_W.
  - Inputs: a, b, cin, op.
  - Outputs: result, cout, zero.
- The register file, IR, PC and FSM live in acc_cpu_core.

## Test plan
- Reset/handshake: assert CLB mid-EXEC → PC=0, ACC=0, Z=1, C=0, INST_REQ=0. Release, hold INST_VALID=0 for 3 cycles → PC=0 and INST_REQ=1 throughout, no state change.
- Arithmetic (DATA_W=8): LDI 0xF, STR R1, repeat ADD R1 until overflow → ACC=0x0E, C=1 after the 17th ADD. ADC R1 then gives 0x1E. SUB R1 with ACC=0x00 gives ACC=0xF1, C=1.
- Flags/branch: ACC=0x00 via XOR R0 (R0=0) → Z=1. R2=0x20, JZ R2 → PC=0x20. Then with Z=0, JZ R2 → PC increments by 1.
- Shifts: ACC=0x81, SHL → ACC=0x02, C=1. SHR → ACC=0x01, C=0.
- PC wrap/halt: start at PC=0xFF with NOP → PC=0x00. Fetch HLT at 0x00 → HALTED=1, PC stays 0x00, INST_REQ stays 0 for 10 cycles. CLB recovers.
- Parametrisation: DATA_W=16, REG_AW=3, PC_W=10 → LDI zero-extends 3-bit field. JMP to R=0x03FF lands PC=0x3FF; next increment wraps to 0.

Source files
------------

// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU core: opcodes, FSM states and
// the ALU operation encoding.
package acc_cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LDR = 4'h2;
    localparam logic [3:0] OP_STR = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SUB = 4'h6;
    localparam logic [3:0] OP_AND = 4'h7;
    localparam logic [3:0] OP_OR  = 4'h8;
    localparam logic [3:0] OP_XOR = 4'h9;
    localparam logic [3:0] OP_SHL = 4'hA;
    localparam logic [3:0] OP_SHR = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_JZ  = 4'hD;
    localparam logic [3:0] OP_JC  = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } tState;

    // ALU_PASS forwards operand b; used for LDI/LDR so Z comes from the ALU.
    typedef enum logic [3:0] {
        ALU_PASS,
        ALU_ADD,
        ALU_ADC,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SHL,
        ALU_SHR
    } tAluOp;

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU for the accumulator core. Arithmetic runs DATA_W+1 wide;
// the extra bit is the carry (or borrow for subtraction).
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    input  tAluOp             op,
    output logic [DATA_W-1:0] result,
    output logic              cout,
    output logic              zero
);

    logic [DATA_W:0] wide;

    always_comb begin
        wide = '0;
        case (op)
            ALU_ADD: wide = {1'b0, a} + {1'b0, b};
            ALU_ADC: wide = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
            ALU_SUB: wide = {1'b0, a} - {1'b0, b};
            ALU_AND: wide = {1'b0, a & b};
            ALU_OR:  wide = {1'b0, a | b};
            ALU_XOR: wide = {1'b0, a ^ b};
            ALU_SHL: wide = {a, 1'b0};
            // Shifted-out LSB lands in the carry position.
            ALU_SHR: wide = {a[0], 1'b0, a[DATA_W-1:1]};
            default: wide = {1'b0, b};
        endcase
    end

    assign result = wide[DATA_W-1:0];
    assign cout   = wide[DATA_W];
    assign zero   = (result == '0);

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU core with request/valid instruction fetch.
// state    | meaning
// ST_FETCH | INST_REQ high, wait for INST_VALID, latch IR
// ST_EXEC  | execute IR, update ACC/flags/regs/PC
// ST_HALT  | sticky stop after HLT, left only by CLB
module acc_cpu_core
    import acc_cpu_pkg::*;
#(
    parameter int  DATA_W = 8,
    parameter int  REG_AW = 4,
    parameter int  PC_W   = 8,
    localparam int INST_W = 4 + REG_AW
) (
    input  logic              CLK,
    input  logic              CLB,
    input  logic [INST_W-1:0] INST,
    input  logic              INST_VALID,
    output logic              INST_REQ,
    output logic [PC_W-1:0]   PC,
    output logic [DATA_W-1:0] ACC,
    output logic              FLAG_Z,
    output logic              FLAG_C,
    output logic              HALTED
);

    localparam int NREG = 2 ** REG_AW;

    tState             state;
    tState             stateNext;
    logic [INST_W-1:0] ir;
    logic [DATA_W-1:0] regFile [NREG];

    logic [3:0]        opcode;
    logic [REG_AW-1:0] field;
    logic [DATA_W-1:0] regVal;
    logic [DATA_W-1:0] aluB;
    logic [DATA_W-1:0] aluResult;
    logic              aluCout;
    logic              aluZero;
    tAluOp             aluOp;
    logic              accWe;
    logic              carryWe;
    logic              regWe;
    logic              jumpTaken;

    assign opcode = ir[INST_W-1 -: 4];
    assign field  = ir[REG_AW-1:0];
    assign regVal = regFile[field];

    acc_cpu_alu #(.DATA_W(DATA_W)) uAlu (
        .a      (ACC),
        .b      (aluB),
        .cin    (FLAG_C),
        .op     (aluOp),
        .result (aluResult),
        .cout   (aluCout),
        .zero   (aluZero)
    );

    always_ff @(posedge CLK or posedge CLB) begin
        if (CLB) state <= ST_FETCH;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        aluOp     = ALU_PASS;
        aluB      = regVal;
        accWe     = 1'b0;
        carryWe   = 1'b0;
        regWe     = 1'b0;
        jumpTaken = 1'b0;
        case (state)
            ST_FETCH: if (INST_VALID) stateNext = ST_EXEC;
            ST_EXEC: begin
                stateNext = ST_FETCH;
                case (opcode)
                    OP_LDI: begin accWe = 1'b1; aluB = DATA_W'(field); end
                    OP_LDR: accWe = 1'b1;
                    OP_STR: regWe = 1'b1;
                    OP_ADD: begin aluOp = ALU_ADD; accWe = 1'b1; carryWe = 1'b1; end
                    OP_ADC: begin aluOp = ALU_ADC; accWe = 1'b1; carryWe = 1'b1; end
                    OP_SUB: begin aluOp = ALU_SUB; accWe = 1'b1; carryWe = 1'b1; end
                    OP_AND: begin aluOp = ALU_AND; accWe = 1'b1; end
                    OP_OR:  begin aluOp = ALU_OR;  accWe = 1'b1; end
                    OP_XOR: begin aluOp = ALU_XOR; accWe = 1'b1; end
                    OP_SHL: begin aluOp = ALU_SHL; accWe = 1'b1; carryWe = 1'b1; end
                    OP_SHR: begin aluOp = ALU_SHR; accWe = 1'b1; carryWe = 1'b1; end
                    OP_JMP: jumpTaken = 1'b1;
                    OP_JZ:  jumpTaken = FLAG_Z;
                    OP_JC:  jumpTaken = FLAG_C;
                    OP_HLT: stateNext = ST_HALT;
                    default: ;
                endcase
            end
            ST_HALT: stateNext = ST_HALT;
            default: stateNext = ST_FETCH;
        endcase
    end

    always_ff @(posedge CLK or posedge CLB) begin
        if (CLB) begin
            PC     <= '0;
            ACC    <= '0;
            ir     <= '0;
            FLAG_Z <= 1'b1;
            FLAG_C <= 1'b0;
            for (int i = 0; i < NREG; i++) regFile[i] <= '0;
        end else begin
            if (state == ST_FETCH && INST_VALID) ir <= INST;
            if (state == ST_EXEC) begin
                if (accWe) begin
                    ACC    <= aluResult;
                    FLAG_Z <= aluZero;
                end
                if (carryWe) FLAG_C <= aluCout;
                if (regWe) regFile[field] <= ACC;
                // Jump targets truncate or zero-extend the register to PC_W.
                if (jumpTaken)              PC <= PC_W'(regVal);
                else if (opcode != OP_HLT)  PC <= PC + PC_W'(1);
            end
        end
    end

    assign INST_REQ = (state == ST_FETCH) && !CLB;
    assign HALTED   = (state == ST_HALT);

endmodule
